// File: rtl/lbp_pkg.sv
// lbp_pkg: shared constants, state encoding and border test for the LBP frame sequencer.
package lbp_pkg;

    localparam int IMG_W        = 128;
    localparam int ADDR_W       = 14;
    localparam int HALF_W       = ADDR_W / 2;
    localparam int FRAME_PIXELS = IMG_W * IMG_W;
    localparam int LBP_PIXELS   = (IMG_W - 2) * (IMG_W - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Low half of a raster address is x, high half is y; the border is any pixel
    // on the first/last row or column.
    function automatic logic is_border(input logic [ADDR_W-1:0] a);
        logic [HALF_W-1:0] x;
        logic [HALF_W-1:0] y;
        x = a[HALF_W-1:0];
        y = a[ADDR_W-1:HALF_W];
        return (x == '0) || (x == '1) || (y == '0) || (y == '1);
    endfunction

endpackage

// File: rtl/lbp_watchdog.sv
// lbp_watchdog: counts consecutive enabled cycles without a kick and flags expiry.
module lbp_watchdog #(
    parameter int                WDOG_W   = 20,
    parameter logic [WDOG_W-1:0] WDOG_MAX = {WDOG_W{1'b1}}
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    input  logic kick,
    output logic expired
);

    logic [WDOG_W-1:0] cnt_q;
    logic [WDOG_W-1:0] cnt_d;

    // cnt_q holds the number of idle cycles already completed; a kick or clear restarts it
    always_comb begin
        cnt_d = (clear || kick) ? '0 : (enable ? cnt_q + 1'b1 : cnt_q);
    end

    // expiry fires on the WDOG_MAX-th consecutive enabled cycle without a kick
    always_comb begin
        expired = enable && !kick && (cnt_q == WDOG_MAX - 1'b1);
    end

    // counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lbp_frame_ctrl.sv
// lbp_frame_ctrl: loads one image, zero-fills the LBP border, runs and supervises the LBP engine.
module lbp_frame_ctrl
    import lbp_pkg::*;
#(
    parameter int                WDOG_W   = 20,
    parameter logic [WDOG_W-1:0] WDOG_MAX = 20'hFFFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err_count,
    output logic              err_timeout,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [7:0]        host_data,
    output logic              gmem_we,
    output logic [ADDR_W-1:0] gmem_addr,
    output logic [7:0]        gmem_wdata,
    output logic              eng_rst,
    output logic              gray_ready,
    input  logic [ADDR_W-1:0] eng_gray_addr,
    input  logic [ADDR_W-1:0] eng_lbp_addr,
    input  logic              eng_lbp_valid,
    input  logic [7:0]        eng_lbp_data,
    input  logic              eng_finish,
    output logic              lmem_we,
    output logic [ADDR_W-1:0] lmem_addr,
    output logic [7:0]        lmem_wdata
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] load_cnt_q, load_cnt_d;
    logic [ADDR_W-1:0] valid_cnt_q, valid_cnt_d;
    logic              err_count_q, err_count_d;
    logic              err_timeout_q, err_timeout_d;
    logic              start_acc;
    logic              in_run;
    logic              wdog_expired;

    assign start_acc   = (state_q == IDLE) && start;
    assign in_run      = (state_q == RUN);
    assign err_count   = err_count_q;
    assign err_timeout = err_timeout_q;

    lbp_watchdog #(
        .WDOG_W   (WDOG_W),
        .WDOG_MAX (WDOG_MAX)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .enable  (in_run),
        .clear   (start_acc),
        .kick    (in_run && eng_lbp_valid),
        .expired (wdog_expired)
    );

    // frame sequencing: next state, pixel counters and sticky error flags
    always_comb begin
        state_d       = state_q;
        load_cnt_d    = load_cnt_q;
        valid_cnt_d   = valid_cnt_q;
        err_count_d   = err_count_q;
        err_timeout_d = err_timeout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load_cnt_d    = '0;
                    valid_cnt_d   = '0;
                    err_count_d   = 1'b0;
                    err_timeout_d = 1'b0;
                    state_d       = LOAD;
                end
            end
            LOAD: begin
                if (host_valid) begin
                    load_cnt_d = load_cnt_q + 1'b1;
                    if (load_cnt_q == ADDR_W'(FRAME_PIXELS - 1)) state_d = RUN;
                end
            end
            RUN: begin
                valid_cnt_d = valid_cnt_q + ADDR_W'(eng_lbp_valid);
                if (eng_finish) begin
                    state_d = DONE;
                end else if (wdog_expired) begin
                    err_timeout_d = 1'b1;
                    state_d       = DONE;
                end
            end
            DONE: begin
                err_count_d = (valid_cnt_q != ADDR_W'(LBP_PIXELS));
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // status outputs and memory port muxes; LOAD owns both memories, RUN hands them to the engine
    always_comb begin
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        eng_rst    = (state_q == IDLE);
        host_ready = (state_q == LOAD);
        gray_ready = in_run;
        gmem_we    = host_ready && host_valid;
        gmem_addr  = in_run ? eng_gray_addr : (host_ready ? load_cnt_q : '0);
        gmem_wdata = gmem_we ? host_data : 8'h00;
        lmem_we    = in_run ? eng_lbp_valid : (gmem_we && is_border(load_cnt_q));
        lmem_addr  = in_run ? eng_lbp_addr : (host_ready ? load_cnt_q : '0);
        lmem_wdata = in_run ? eng_lbp_data : 8'h00;
    end

    // state and counter registers; reset aborts any frame in progress
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            load_cnt_q    <= '0;
            valid_cnt_q   <= '0;
            err_count_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_cnt_q    <= load_cnt_d;
            valid_cnt_q   <= valid_cnt_d;
            err_count_q   <= err_count_d;
            err_timeout_q <= err_timeout_d;
        end
    end

endmodule
